// File: rtl/i2c_slave_regs.sv
// I2C register target: START/STOP/Sr decode, 7-bit address match, pointer-based writes and sequential reads.
// Latency: SDA follows a pin SCL fall by at most FILT_LEN+3 clk; no backpressure, SCL is never stretched.
module i2c_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1a,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // One conditioned pin: 2-FF synchronizer, stability filter and previous filtered level.
  typedef struct packed {
    logic       s1;
    logic       s2;
    logic       lvl;
    logic       prev;
    logic [2:0] cnt;
  } line_t;

  localparam logic [2:0] FILT_LAST = 3'(FILT_LEN - 1);
  localparam line_t LINE_IDLE = '{s1: 1'b1, s2: 1'b1, lvl: 1'b1, prev: 1'b1, cnt: 3'd0};

  function automatic line_t line_step(input line_t cur, input logic raw);
    line_t nxt;
    nxt      = cur;
    nxt.s1   = raw;
    nxt.s2   = cur.s1;
    nxt.prev = cur.lvl;
    if (cur.s2 != cur.lvl) begin
      if (cur.cnt == FILT_LAST) begin
        nxt.lvl = cur.s2;
        nxt.cnt = 3'd0;
      end else begin
        nxt.cnt = cur.cnt + 3'd1;
      end
    end else begin
      nxt.cnt = 3'd0;
    end
    return nxt;
  endfunction

  line_t scl_l;
  line_t sda_l;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      scl_l <= LINE_IDLE;
      sda_l <= LINE_IDLE;
    end else begin
      scl_l <= line_step(scl_l, scl_in);
      sda_l <= line_step(sda_l, sda_in);
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic sda_rise;
  logic sda_fall;
  logic start_cond;
  logic stop_cond;

  assign scl_rise   = scl_l.lvl & ~scl_l.prev;
  assign scl_fall   = ~scl_l.lvl & scl_l.prev;
  assign sda_rise   = sda_l.lvl & ~sda_l.prev;
  assign sda_fall   = ~sda_l.lvl & sda_l.prev;
  assign start_cond = sda_fall & scl_l.lvl;
  assign stop_cond  = sda_rise & scl_l.lvl;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] tx_byte;
  logic [7:0] pointer;
  logic       rw;
  logic [7:0] rx_byte;

  assign rx_byte = {shreg, sda_l.lvl};
  assign rd_addr = pointer;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 7'd0;
      tx_byte <= 8'd0;
      pointer <= 8'd0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= 1'b0;
      if (start_cond) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_cond) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == ADDR) begin
                  if (rx_byte[7:1] != SLAVE_ADDR) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                  rw <= rx_byte[0];
                end else if (state == REG) begin
                  pointer <= rx_byte;
                end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= pointer;
                  wr_data <= rx_byte;
                  pointer <= pointer + 8'd1;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                busy  <= 1'b1;
                state <= ADDR_ACK;
              end else if (state == REG) begin
                state <= REG_ACK;
              end else begin
                state <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                tx_byte <= {rd_data[6:0], 1'b0};
                sda_oe  <= ~rd_data[7];
                state   <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= REG;
              end
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= RDATA_ACK;
              end else begin
                sda_oe  <= ~tx_byte[7];
                tx_byte <= tx_byte << 1;
              end
            end
          end
          RDATA_ACK: begin
            // bit_cnt==1 marks "master ACKed, next byte starts on the coming fall"
            if (scl_rise) begin
              pointer <= pointer + 8'd1;
              if (!sda_l.lvl) begin
                bit_cnt <= 4'd1;
              end else begin
                state <= IDLE;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              tx_byte <= {rd_data[6:0], 1'b0};
              sda_oe  <= ~rd_data[7];
              bit_cnt <= 4'd0;
              state   <= RDATA;
            end
          end
          default: begin
            bit_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Scoreboarded bench for i2c_slave_regs: a bit-banged master issues directed transfers and queues the
// expected ACK bits, read bytes, write strobes and status values; one monitor process compares them.
module tb_i2c_slave_regs;

  localparam int QT = 400;

  localparam int SEL_OE    = 0;
  localparam int SEL_BUSY  = 1;
  localparam int SEL_RDA   = 2;
  localparam int SEL_WREN  = 3;
  localparam int SEL_WADDR = 4;
  localparam int SEL_WDATA = 5;
  localparam int SEL_VAL   = 6;

  typedef struct {
    int         nbits;
    logic [7:0] val;
    string      name;
  } sda_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       scl_in  = 1'b1;
  logic       sda_m   = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_en;
  logic       busy;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] perturb = 8'h00;

  logic slot_on   = 1'b0;
  logic watch     = 1'b0;
  logic seen_oe   = 1'b0;
  logic seen_busy = 1'b0;
  logic scl_prev  = 1'b1;
  logic [7:0] rx_bits = 8'h00;
  int   rx_n      = 0;
  int   wr_seen   = 0;
  int   checks    = 0;
  int   failures  = 0;

  sda_exp_t sda_q[$];
  wr_exp_t  wr_q[$];
  chk_t     chk_q[$];

  sda_exp_t se;
  wr_exp_t  we;
  chk_t     cq;
  logic [31:0] g;
  logic [7:0]  mask;

  assign sda_in  = sda_m & ~sda_oe;
  assign rd_data = rd_addr ^ 8'hFF ^ perturb;

  always #10 clk_50m = ~clk_50m;

  i2c_slave_regs #(.SLAVE_ADDR(7'h1a), .FILT_LEN(3)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // Single monitor: pops every scoreboard queue as the DUT presents the matching output.
  always @(negedge clk_50m) begin
    if (watch) begin
      if (sda_oe === 1'b1) seen_oe = 1'b1;
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    if (wr_en === 1'b1) begin
      wr_seen++;
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got addr=%02h data=%02h required no write", wr_addr, wr_data);
      end else begin
        we = wr_q.pop_front();
        if ({wr_addr, wr_data} !== {we.addr, we.data}) begin
          failures++;
          $display("FAIL wr_strobe got addr=%02h data=%02h required addr=%02h data=%02h",
                   wr_addr, wr_data, we.addr, we.data);
        end
      end
    end
    if (slot_on && scl_in && !scl_prev) begin
      if (sda_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sda_unexpected got bit=%0b required no slot", sda_in);
      end else begin
        rx_bits = {rx_bits[6:0], sda_in};
        rx_n++;
        if (rx_n == sda_q[0].nbits) begin
          se   = sda_q.pop_front();
          mask = (se.nbits == 8) ? 8'hFF : 8'h01;
          checks++;
          if ((rx_bits & mask) !== (se.val & mask)) begin
            failures++;
            $display("FAIL %s got=%02h required=%02h", se.name, rx_bits & mask, se.val & mask);
          end
          rx_n    = 0;
          rx_bits = 8'h00;
        end
      end
    end
    scl_prev = scl_in;
    while (chk_q.size() > 0) begin
      cq = chk_q.pop_front();
      case (cq.sel)
        SEL_OE:    g = {31'd0, sda_oe};
        SEL_BUSY:  g = {31'd0, busy};
        SEL_RDA:   g = {24'd0, rd_addr};
        SEL_WREN:  g = {31'd0, wr_en};
        SEL_WADDR: g = {24'd0, wr_addr};
        SEL_WDATA: g = {24'd0, wr_data};
        default:   g = cq.got;
      endcase
      checks++;
      if (g !== cq.exp) begin
        failures++;
        $display("FAIL %s got=%0h required=%0h", cq.name, g, cq.exp);
      end
    end
  end

  task automatic expect_sig(input string nm, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.got  = 32'd0;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.sel  = SEL_VAL;
    c.got  = got;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    wr_exp_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic expect_sda(input int n, input logic [7:0] v, input string nm);
    sda_exp_t e;
    e.nbits = n;
    e.val   = v;
    e.name  = nm;
    sda_q.push_back(e);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(QT);
    scl_in = 1'b1; #(QT);
    sda_m = 1'b0; #(QT);
    scl_in = 1'b0; #(QT);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(QT);
    scl_in = 1'b1; #(QT);
    sda_m = 1'b1; #(QT);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #(QT);
    scl_in = 1'b1; #(2 * QT);
    scl_in = 1'b0; #(QT);
  endtask

  task automatic ack_slot(input logic ack, input string nm);
    expect_sda(1, {7'd0, ack}, nm);
    slot_on = 1'b1;
    send_bit(1'b1);
    slot_on = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack, input string nm);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    ack_slot(ack, nm);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack, input logic pert, input string nm);
    expect_sda(8, exp, nm);
    slot_on = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (pert && i == 4) perturb = 8'h0F;
      send_bit(1'b1);
    end
    slot_on = 1'b0;
    perturb = 8'h00;
    send_bit(~mack);
  endtask

  // Bit 5 carries a 2-cycle SDA dip while SCL is high; bit 0 carries a 2-cycle SCL low pulse.
  task automatic send_glitch_byte(input logic [7:0] v, input string nm);
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) begin
        sda_m = v[i]; #(QT);
        scl_in = 1'b1; #(QT);
        sda_m = ~v[i]; #40;
        sda_m = v[i]; #(QT - 40);
        scl_in = 1'b0; #(QT);
      end else if (i == 0) begin
        sda_m = v[i]; #(QT);
        scl_in = 1'b1; #(QT);
        scl_in = 1'b0; #40;
        scl_in = 1'b1; #(QT - 40);
        scl_in = 1'b0; #(QT);
      end else begin
        send_bit(v[i]);
      end
    end
    ack_slot(1'b0, nm);
  endtask

  initial begin
    @(negedge clk_50m);
    #5;
    rst = 1'b1;
    #(20 * 5);
    expect_sig("rst_sda_oe", SEL_OE, 0);
    expect_sig("rst_wr_en", SEL_WREN, 0);
    expect_sig("rst_wr_addr", SEL_WADDR, 0);
    expect_sig("rst_wr_data", SEL_WDATA, 0);
    expect_sig("rst_rd_addr", SEL_RDA, 0);
    expect_sig("rst_busy", SEL_BUSY, 0);
    #20;
    rst = 1'b0;
    #(20 * 10);

    // write burst
    i2c_start();
    send_byte(8'h34, 1'b0, "ack_addr_w");
    expect_sig("busy_addressed", SEL_BUSY, 1);
    send_byte(8'h04, 1'b0, "ack_reg04");
    expect_wr(8'h04, 8'h55);
    send_byte(8'h55, 1'b0, "ack_d55");
    expect_wr(8'h05, 8'hAA);
    send_byte(8'hAA, 1'b0, "ack_dAA");
    expect_sig("busy_before_stop", SEL_BUSY, 1);
    i2c_stop();
    #(QT);
    expect_sig("busy_after_stop", SEL_BUSY, 0);
    expect_sig("ptr_after_burst", SEL_RDA, 8'h06);

    // wrong address
    watch = 1'b1;
    i2c_start();
    send_byte(8'h36, 1'b1, "nack_addr_miss");
    send_byte(8'h04, 1'b1, "nack_after_miss");
    i2c_stop();
    #(QT);
    watch = 1'b0;
    #20;
    expect_val("no_oe_on_miss", {31'd0, seen_oe}, 0);
    expect_val("no_busy_on_miss", {31'd0, seen_busy}, 0);

    // combined write-pointer / repeated-start read
    i2c_start();
    send_byte(8'h34, 1'b0, "ack_addr_w2");
    send_byte(8'h10, 1'b0, "ack_ptr10");
    i2c_start();
    send_byte(8'h35, 1'b0, "ack_addr_r");
    expect_sig("rd_addr_ptr10", SEL_RDA, 8'h10);
    read_byte(8'hEF, 1'b1, 1'b1, "rd_byte0");
    expect_sig("rd_addr_after_ack", SEL_RDA, 8'h11);
    read_byte(8'hEE, 1'b0, 1'b0, "rd_byte1");
    expect_sig("rd_addr_after_nack", SEL_RDA, 8'h12);
    expect_sig("sda_released_nack", SEL_OE, 0);
    expect_sig("busy_until_stop", SEL_BUSY, 1);
    i2c_stop();
    #(QT);
    expect_sig("busy_after_read", SEL_BUSY, 0);

    // pointer wrap
    i2c_start();
    send_byte(8'h34, 1'b0, "ack_addr_wrap");
    send_byte(8'hFF, 1'b0, "ack_ptrFF");
    expect_wr(8'hFF, 8'h01);
    send_byte(8'h01, 1'b0, "ack_d01");
    expect_wr(8'h00, 8'h02);
    send_byte(8'h02, 1'b0, "ack_d02");
    i2c_stop();
    #(QT);
    expect_sig("ptr_after_wrap", SEL_RDA, 8'h01);

    // glitch rejection
    i2c_start();
    send_byte(8'h34, 1'b0, "ack_addr_glitch");
    send_glitch_byte(8'h20, "ack_ptr20_glitch");
    expect_sig("busy_after_glitch", SEL_BUSY, 1);
    expect_wr(8'h20, 8'h5A);
    send_byte(8'h5A, 1'b0, "ack_d5A");
    i2c_stop();
    #(QT);
    expect_sig("ptr_after_glitch", SEL_RDA, 8'h21);

    // reset during a read: pointer 0x21 gives byte 0xDE, third bit is 0
    i2c_start();
    send_byte(8'h35, 1'b0, "ack_addr_r2");
    send_bit(1'b1);
    send_bit(1'b1);
    sda_m = 1'b1; #(QT);
    scl_in = 1'b1; #(QT);
    expect_sig("oe_before_rst", SEL_OE, 1);
    #20;
    rst = 1'b1;
    #20;
    expect_sig("oe_after_rst", SEL_OE, 0);
    expect_sig("busy_after_rst", SEL_BUSY, 0);
    expect_sig("rd_addr_after_rst", SEL_RDA, 0);
    expect_sig("wr_en_after_rst", SEL_WREN, 0);
    #20;
    rst = 1'b0;
    #(QT);
    scl_in = 1'b0; #(QT);
    i2c_stop();
    #(QT);
    i2c_start();
    send_byte(8'h34, 1'b0, "ack_addr_post");
    send_byte(8'h07, 1'b0, "ack_ptr07");
    expect_wr(8'h07, 8'h99);
    send_byte(8'h99, 1'b0, "ack_d99");
    i2c_stop();
    #(QT);

    expect_val("wr_count", wr_seen, 6);
    expect_val("wr_q_drained", wr_q.size(), 0);
    expect_val("sda_q_drained", sda_q.size(), 0);
    #60;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder), the counterpart of the codec-configuration I2C master.
- Serves as a bus-functional and synthesizable register target: it checks the master path in simulation and exposes an 8-bit register map to a second I2C controller.
- Decodes START, STOP and repeated START, matches a 7-bit address, and ACKs bytes.
- Performs pointer-based register writes and sequential reads through a simple parallel register port.

Parameters:
- SLAVE_ADDR, 7'h1a, 7-bit I2C address this block responds to.
- FILT_LEN, 3, number of consecutive stable samples required before a filtered SCL/SDA level changes (range 1..7).

Ports:
- clk_50m  input  1  system clock; all logic in this domain.
- rst  input  1  reset, synchronous, active-high.
- scl_in  input  1  raw SCL pin level (asynchronous).
- sda_in  input  1  raw SDA pin level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; top level implements open-drain (SDA = sda_oe ? 0 : Z).
- wr_en  output  1  one-cycle register write strobe.
- wr_addr  output  8  register address for the write.
- wr_data  output  8  register data for the write.
- rd_addr  output  8  register address being read (current pointer).
- rd_data  input  8  register contents at rd_addr; combinational, valid in the same cycle.
- busy  output  1  high while addressed (from address ACK until STOP or a non-matching restart).

Behaviour:
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0. Reset also sets state=IDLE, pointer=0x00, bit counter=0 and both filters to 1.
- Input conditioning:
  - 2-FF synchronizer on each of SCL and SDA.
  - Followed by a filter: the filtered level updates only after the synced input has differed from it for FILT_LEN consecutive cycles.
  - Registered edge detect on the filtered signals yields scl_rise, scl_fall, sda_rise and sda_fall.
- Bus conditions, evaluated on filtered signals:
  - START / repeated START = sda_fall while SCL high. Go to ADDR with bit count 0 from any state; sda_oe=0.
  - STOP = sda_rise while SCL high. Go to IDLE from any state; sda_oe=0; busy=0.
  - START/STOP take priority over any data-bit action in the same cycle.
- Data sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, never while SCL is high.
  - Resulting SDA latency is at most FILT_LEN+3 cycles after the pin's SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - IDLE: ignore SCL activity until START.
  - ADDR: shift in 8 bits, MSB first.
    - On the 8th scl_rise, compare bits[7:1] with SLAVE_ADDR.
    - Match: on the next scl_fall set sda_oe=1 and busy=1, enter ADDR_ACK.
    - Mismatch: go to IDLE with no ACK.
  - ADDR_ACK: on scl_fall, release SDA.
    - R/W=0: enter REG.
    - R/W=1: drive bit 7 of rd_data at rd_addr=pointer, enter RDATA.
  - REG: on the 8th bit, load pointer and rd_addr with the byte; ACK as above; enter REG_ACK, then WDATA.
  - WDATA:
    - On the 8th scl_rise, pulse wr_en for one cycle with wr_addr=pointer and wr_data=byte.
    - Pointer increments, 0xFF wraps to 0x00.
    - ACK, enter WDATA_ACK, then WDATA again.
  - RDATA:
    - Drive sda_oe = ~bit, MSB first, changing on each scl_fall.
    - After the 8th bit's scl_fall, release SDA and enter RDATA_ACK.
  - RDATA_ACK: sample the master ACK on scl_rise.
    - ACK (SDA=0): pointer++ (wrap), rd_addr=pointer, latch rd_data on the next scl_fall and drive its MSB, enter RDATA.
    - NACK: keep SDA released and wait for STOP/START; the pointer still increments.
- rd_data is captured once per byte, at the scl_fall that begins the byte; later changes to rd_data do not affect the byte in flight.
- The pointer persists across transactions. A read without a preceding register write starts at the last pointer value.
- Reset asserted mid-transfer: SDA is released on the next cycle and no wr_en is issued.
- Never drives SDA high and never drives SCL (no clock stretching).

Test Plan:
- Write burst: START, 0x34, 0x04, 0x55, 0xAA, STOP → ACK on all 4 bytes; wr_en pulses (0x04,0x55) then (0x05,0xAA); busy 1→0 at STOP.
- Wrong address: START, 0x36, 0x04 → SDA never pulled low, no wr_en, busy stays 0.
- Combined read: write pointer 0x10, Sr, 0x35; rd_data model = addr^0xFF; master ACKs byte 1 and NACKs byte 2 → bytes 0xEF, 0xEE on SDA; rd_addr 0x10→0x11→0x12; SDA released after NACK.
- Pointer wrap: write pointer 0xFF, data 0x01, 0x02 → writes at 0xFF then 0x00.
- Glitch rejection (FILT_LEN=3): 2-cycle low pulse on SCL mid-bit and 2-cycle SDA glitch while SCL high → no bit shift, no false START/STOP, the following byte decodes correctly.
- Reset mid-read: assert rst during bit 3 of RDATA while sda_oe=1 → sda_oe=0 next cycle, state IDLE; next transaction with START decodes normally.
